dmem_arbiter: RTL and testbench

//  - Sequences and shares the 256x64 data RAM between two requesters.
//  - Port A: CPU load/store unit. Port B: secondary master (program loader/debug).
//  - Valid/ready request handshake per port, one-cycle response pulse per port.
//  - Drives the RAM address/in/write pins from registers so they are stable

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_pick.sv | 38 +++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration (see dmem_arb_pick).
package dmem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  // Requester identifiers, also used for last_grant bookkeeping.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two request ports.
// Build option DMEM_ARB_RR_EN: when defined, contention goes to the port that
// did not win last time; otherwise port A always wins on contention.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin: a lone requester always wins; on contention alternate.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = (last_grant == PORT_B);
      grant_b = (last_grant == PORT_A);
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end
`else
  // Fixed priority: A beats B whenever both are requesting.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid && !a_valid;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the 256x64 data RAM.
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; ready is only offered in IDLE, to the winner only,
// and never while reset is asserted. Each accepted request produces exactly
// one rsp_valid pulse, one cycle long, in the cycle after the access edge.
// RAM pins are driven from registers so they are stable at the RAM negedge.
// Build option: DMEM_ARB_RR_EN (round-robin arbitration, see dmem_arb_pick).
module dmem_arbiter #(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  input  logic              a_req_write,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  input  logic              b_req_write,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              dbg_state
);
  import dmem_arb_pkg::*;

  state_t state, state_nxt;
  logic   last_grant;
  logic   cur_id;
  logic   grant_a, grant_b;
  logic   hs_a, hs_b;

  dmem_arb_pick u_pick (
    .a_valid    (a_req_valid),
    .b_valid    (b_req_valid),
    .last_grant (last_grant),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  assign hs_a      = a_req_valid && a_req_ready;
  assign hs_b      = b_req_valid && b_req_ready;
  assign dbg_state = (state == ACCESS);

  // Next state and ready: offer ready to the winner only while idle.
  always_comb begin
    state_nxt   = state;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    case (state)
      IDLE: begin
        a_req_ready = grant_a && reset_n;
        b_req_ready = grant_b && reset_n;
        if (grant_a || grant_b) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; a lone valid always yields a handshake, so winner implies transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // RAM-side registers: capture the accepted request, drop write after the access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_address <= '0;
      ram_in      <= '0;
      ram_write   <= 1'b0;
      cur_id      <= PORT_A;
      last_grant  <= PORT_B;
    end else if (hs_a) begin
      ram_address <= a_req_addr;
      ram_in      <= a_req_wdata;
      ram_write   <= a_req_write;
      cur_id      <= PORT_A;
      last_grant  <= PORT_A;
    end else if (hs_b) begin
      ram_address <= b_req_addr;
      ram_in      <= b_req_wdata;
      ram_write   <= b_req_write;
      cur_id      <= PORT_B;
      last_grant  <= PORT_B;
    end else if (state == ACCESS) begin
      ram_write <= 1'b0;
    end
  end

  // Response registers: pulse the owner's rsp_valid and capture read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_rdata <= '0;
      b_rsp_rdata <= '0;
    end else begin
      a_rsp_valid <= (state == ACCESS) && (cur_id == PORT_A);
      b_rsp_valid <= (state == ACCESS) && (cur_id == PORT_B);
      // ram_write still holds this access's direction at its closing edge.
      if (state == ACCESS && !ram_write) begin
        if (cur_id == PORT_A) a_rsp_rdata <= ram_out;
        else                  b_rsp_rdata <= ram_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: RAM model, transaction-level reference
// model with per-port expected-response queues, directed and random stimulus.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          a_req_valid = 0, a_req_write = 0;
  logic [AW-1:0] a_req_addr = '0;
  logic [DW-1:0] a_req_wdata = '0;
  logic          b_req_valid = 0, b_req_write = 0;
  logic [AW-1:0] b_req_addr = '0;
  logic [DW-1:0] b_req_wdata = '0;
  logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in;
  logic          ram_write;
  logic [DW-1:0] ram_out = '0;
  logic          dbg_state;

  dmem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_req_write(a_req_write),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_req_write(b_req_write),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_address(ram_address), .ram_in(ram_in), .ram_write(ram_write),
    .ram_out(ram_out), .dbg_state(dbg_state)
  );

  // ---------------- RAM (negedge sampled, registered out) ----------------
  logic [DW-1:0] ram_mem [256];
  initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;
  always @(negedge clock) begin
    if (ram_write) ram_mem[ram_address] = ram_in;
    ram_out <= ram_mem[ram_address];
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Whole-transaction view: one access in flight at a time, completes on the
  // edge after acceptance; memory updated at completion.
  logic [DW-1:0] gold [256];
  initial for (int i = 0; i < 256; i++) gold[i] = '0;

  bit            m_busy, m_port, m_wr, m_last, m_rsp_a, m_rsp_b;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd_a, m_rd_b;
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];

  function automatic bit pick_b(input bit va, input bit vb, input bit last);
    if (!(va && vb)) return vb;
`ifdef DMEM_ARB_RR_EN
    return (last == 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_rsp_a = 0; m_rsp_b = 0; m_last = 1;
      m_rd_a = '0; m_rd_b = '0;
      exp_q_a.delete(); exp_q_b.delete();
    end else begin
      m_rsp_a = 0; m_rsp_b = 0;
      if (m_busy) begin
        if (m_wr) gold[m_addr] = m_wd;
        else if (m_port) m_rd_b = gold[m_addr];
        else m_rd_a = gold[m_addr];
        if (m_port) begin m_rsp_b = 1; exp_q_b.push_back(m_rd_b); end
        else begin m_rsp_a = 1; exp_q_a.push_back(m_rd_a); end
        m_busy = 0;
      end else if (a_req_valid || b_req_valid) begin
        m_port = pick_b(a_req_valid, b_req_valid, m_last);
        m_wr   = m_port ? b_req_write : a_req_write;
        m_addr = m_port ? b_req_addr  : a_req_addr;
        m_wd   = m_port ? b_req_wdata : a_req_wdata;
        m_last = m_port;
        m_busy = 1;
      end
    end
  end

  // Compare process: every cycle out of reset, mid-cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      bit wb;
      logic [DW-1:0] e;
      wb = pick_b(a_req_valid, b_req_valid, m_last);
      chk("a_ready", a_req_ready, !m_busy && a_req_valid && !wb);
      chk("b_ready", b_req_ready, !m_busy && b_req_valid && wb);
      chk("ram_write", ram_write, m_busy && m_wr);
      if (m_busy) begin
        chk("ram_address", ram_address, m_addr);
        chk("ram_in", ram_in, m_wd);
      end
      chk("a_rsp_valid", a_rsp_valid, m_rsp_a);
      chk("b_rsp_valid", b_rsp_valid, m_rsp_b);
      if (a_rsp_valid) begin
        if (exp_q_a.size() == 0) chk("a_rsp_unexpected", 1, 0);
        else begin e = exp_q_a.pop_front(); chk("a_rsp_rdata", a_rsp_rdata, e); end
      end
      if (b_rsp_valid) begin
        if (exp_q_b.size() == 0) chk("b_rsp_unexpected", 1, 0);
        else begin e = exp_q_b.pop_front(); chk("b_rsp_rdata", b_rsp_rdata, e); end
      end
      chk("a_rdata_hold", a_rsp_rdata, m_rd_a);
      chk("b_rdata_hold", b_rsp_rdata, m_rd_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit port, input bit v, input bit wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port) begin b_req_valid = v; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd; end
    else      begin a_req_valid = v; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd; end
  endtask

  // Issue one request and wait for its response; called at posedge+2.
  task automatic op(input bit port, input bit wr, input logic [AW-1:0] addr,
                    input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                    output int lat, output time hs_t);
    bit got;
    got = 0; lat = 0; rd = '0; hs_t = 0;
    set_req(port, 1, wr, addr, wd);
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clock);
      got = port ? b_req_ready : a_req_ready;
    end
    chk("op_accept", got, 1);
    @(posedge clock);
    hs_t = $time;
    #2;
    set_req(port, 0, 0, '0, '0);
    if (!got) return;
    while (lat < 20 && !(port ? b_rsp_valid : a_rsp_valid)) begin
      @(posedge clock); #1; lat++;
    end
    rd = port ? b_rsp_rdata : a_rsp_rdata;
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return AW'($urandom_range(1, 12));
  endfunction

  // ---------------- stimulus ----------------
  logic [DW-1:0] rd;
  int            lat;
  time           t0, t1;
  logic [7:0]    bits;
  int            n_acc, n_g;
  bit            acc_a, acc_b;

  initial begin
    // Reset values.
    #1;
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_a_rdata", a_rsp_rdata, 0);
    chk("rst_b_rdata", b_rsp_rdata, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clock); #2;
    reset_n = 1;
    @(posedge clock); #2;

    // A write then read back, two-cycle spacing, one-edge latency.
    op(0, 1, 8'h05, 64'hDEAD_BEEF_0000_0001, rd, lat, t0);
    chk("t2_wr_latency", lat, 1);
    op(0, 0, 8'h05, '0, rd, lat, t1);
    chk("t2_rd_latency", lat, 1);
    chk("t2_rd_data", rd, 64'hDEAD_BEEF_0000_0001);
    chk("t2_spacing", t1 - t0, 20);

    // Address extremes via B.
    op(1, 1, 8'hFF, 64'h1, rd, lat, t0);
    op(1, 1, 8'h00, 64'h2, rd, lat, t0);
    op(1, 0, 8'hFF, '0, rd, lat, t0);
    chk("t4_rd_ff", rd, 64'h1);
    op(1, 0, 8'h00, '0, rd, lat, t0);
    chk("t4_rd_00", rd, 64'h2);

    // Seed data for the contention test.
    op(0, 1, 8'h10, 64'h1010_1010_AAAA_0001, rd, lat, t0);
    op(1, 1, 8'h20, 64'h2020_2020_BBBB_0002, rd, lat, t0);

    // Reset mid-run while both ports are active.
    set_req(0, 1, 0, 8'h40, '0);
    set_req(1, 1, 0, 8'h41, '0);
    @(posedge clock); #3;
    reset_n = 0;
    #1;
    chk("t1_a_ready", a_req_ready, 0);
    chk("t1_b_ready", b_req_ready, 0);
    chk("t1_a_rsp", a_rsp_valid, 0);
    chk("t1_b_rsp", b_rsp_valid, 0);
    chk("t1_ram_write", ram_write, 0);
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(posedge clock); #2;
    reset_n = 1;
    #1;
    chk("t1_idle_on_release", dbg_state, 0);
    @(posedge clock); #2;

    // Contention: both read every cycle.
    set_req(0, 1, 0, 8'h10, '0);
    set_req(1, 1, 0, 8'h20, '0);
    bits = '0; n_g = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (a_req_ready || b_req_ready) begin
        if (n_g < 8) bits[n_g] = b_req_ready;
        n_g++;
      end
      @(posedge clock); #2;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (3) @(posedge clock);
    #2;
    chk("t3_grant_count", n_g, 4);
`ifdef DMEM_ARB_RR_EN
    chk("t3_grant_seq", bits[3:0], 4'b1010);
    chk("t3_b_rdata", b_rsp_rdata, 64'h2020_2020_BBBB_0002);
`else
    chk("t3_grant_seq", bits[3:0], 4'b0000);
    chk("t3_b_rdata", b_rsp_rdata, 64'h0);
`endif
    chk("t3_a_rdata", a_rsp_rdata, 64'h1010_1010_AAAA_0001);

    // Reset during an A write access to 0x30.
    set_req(0, 1, 1, 8'h30, 64'hFFFF_0000_3030_3030);
    begin
      bit got;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clock); got = a_req_ready; end
      chk("t5_accept", got, 1);
    end
    @(posedge clock); #2;
    set_req(0, 0, 0, '0, '0);
    reset_n = 0;
    #1;
    chk("t5_ram_write", ram_write, 0);
    chk("t5_a_rsp", a_rsp_valid, 0);
    @(posedge clock); #1;
    chk("t5_a_rsp_later", a_rsp_valid, 0);
    #1;
    reset_n = 1;
    @(posedge clock); #2;
    op(0, 0, 8'h30, '0, rd, lat, t0);
    chk("t5_not_written", rd, 64'h0);

    // B alone, four back-to-back reads.
    n_acc = 0; bits = '0;
    set_req(1, 1, 0, 8'h05, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bits[i] = b_req_ready;
      acc_b = b_req_ready;
      @(posedge clock); #2;
      if (acc_b) begin
        n_acc++;
        if (n_acc == 4) set_req(1, 0, 0, '0, '0);
        else set_req(1, 1, 0, AW'(n_acc == 1 ? 8'hFF : (n_acc == 2 ? 8'h00 : 8'h10)), '0);
      end
    end
    chk("t6_ready_pattern", bits, 8'h55);
    chk("t6_accepts", n_acc, 4);
    repeat (2) @(posedge clock);
    #2;

    // Random traffic on both ports.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      acc_a = a_req_valid && a_req_ready;
      acc_b = b_req_valid && b_req_ready;
      @(posedge clock); #2;
      if (!a_req_valid || acc_a)
        set_req(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                {$urandom, $urandom});
      if (!b_req_valid || acc_b)
        set_req(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                {$urandom, $urandom});
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (4) @(posedge clock);
    #2;
    chk("drain_a", exp_q_a.size(), 0);
    chk("drain_b", exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
